uart_reg_slave: RTL and testbench
=================================

Name: uart_reg_slave

Overview:
- UART-side register slave that receives command frames produced by the team's UART command master, and returns read data to that master's receive path.
- Decodes each command header (rw_flag + 7-bit address) and, for writes, a following data byte.
- Writes land in an internal 128x8 register file, mirrored to a write strobe port; reads trigger a single response frame on tx.
- Serial format: 115200 baud at 50 MHz, 1 start bit, 8 data bits LSB first, odd parity, 1 stop bit.

Parameters:
CLK_PER_BIT, 434, clocks per UART bit
SAMPLE_POINT, 216, bit-counter value at which rx is sampled
CMD_ADDR_WIDTH, 7, address width; register file depth = 2**CMD_ADDR_WIDTH
CMD_DATA_WIDTH, 8, register/data width
DATA_TIMEOUT, 4340, clocks allowed from header stop-sample to data-byte start edge
RESP_DELAY, 200, idle clocks between read-header stop-sample and response start bit

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  asynchronous reset, active-high
rx  input  1  serial in, async to clk (driven by master tx), idle high
tx  output  1  serial out (to master rx), idle high
wr_valid  output  1  one-cycle pulse per accepted register write
wr_addr  output  CMD_ADDR_WIDTH  address of accepted write
wr_data  output  CMD_DATA_WIDTH  data of accepted write
err_cnt  output  8  parity/framing/timeout/overrun error count (see Optional Feature)

Behaviour:
- Reset (async, rst=1) clears all state:
  - tx=1, wr_valid=0, wr_addr=0, wr_data=0, err_cnt=0.
  - Every register file entry = 0.
  - Both FSMs return to their idle states.
- Rx front end:
  - rx passes through a 3-flop shift; bits [1:0] synchronise, [2] is rx_sync.
  - A falling edge of rx_sync is detected only when the byte receiver is idle.
- Byte receiver:
  - After the edge, a bit counter runs 0..CLK_PER_BIT-1 and a bit index runs 0..10.
  - Sampling happens at SAMPLE_POINT.
  - Bit 0 (start) sampled high: false start; receiver returns to idle silently, with no error counted.
  - Bits 1-8 shift in LSB first.
  - Bit 9 is parity; the frame is good only if the 9 bits have odd ones count.
  - Bit 10 is the stop bit and must be 1.
  - At the bit-10 sample the receiver emits byte_done plus an ok flag (parity and stop both good), then returns to idle immediately, re-armed for the next edge.
- Protocol FSM (rx side), states R_HDR, R_DATA:
  - R_HDR, good byte with bit7=0 (read): issue a read request for addr=byte[6:0]; stay in R_HDR.
  - R_HDR, good byte with bit7=1 (write): latch addr, go to R_DATA, start timeout counter.
  - R_DATA, good byte: write regfile[addr]. In the same cycle, wr_valid=1 with wr_addr/wr_data; both hold until the next write. Return to R_HDR.
  - R_DATA, timeout counter reaches DATA_TIMEOUT with no start edge: count error, return to R_HDR. The counter stops once a start edge is seen.
  - Any bad byte (parity or stop) in either state: count error, return to R_HDR, no write.
- Response FSM (tx side), states T_IDLE, T_DLY, T_SEND:
  - A read request in T_IDLE latches regfile[addr] (reflecting any write completed earlier or in the same cycle) and goes to T_DLY.
  - T_DLY counts RESP_DELAY clocks, then goes to T_SEND.
  - T_SEND drives 11 bits of CLK_PER_BIT clocks each: 0, data LSB first, parity = XNOR-reduce of data, 1. Then T_IDLE.
  - tx is registered; first start-bit cycle is 1 clock after T_DLY expiry.
  - A read request while not in T_IDLE is dropped and counted as overrun.
- Rx and tx run concurrently (full duplex); writes are accepted during T_DLY/T_SEND.
- Write and read in the same cycle cannot occur: there is only one byte_done per cycle.
- Reset asserted mid-frame aborts both directions; tx returns to 1 in the same cycle.

Optional Feature:
UART_SLV_ERR_CNT_EN
- Defined: err_cnt increments by 1 per error event (bad parity, bad stop, data timeout, read overrun) and saturates at 255.
- Undefined: no counter logic; err_cnt tied to 0. All other behaviour is identical.

Test Plan:
- Read reset state: rx frame 0x05 (read addr 5) -> after RESP_DELAY, tx frame data 0x00 with parity bit 1; err_cnt=0.
- Write then read:
  - rx frames 0x8A, 100 clk gap, 0x3C -> wr_valid pulse with wr_addr=0x0A, wr_data=0x3C.
  - Then rx frame 0x0A -> tx returns 0x3C with parity bit 1.
- Parity error: rx 0x85 with parity bit flipped -> no wr_valid, FSM stays in R_HDR, err_cnt=1 (0 without macro). A following good read of addr 5 still answers.
- Data timeout: rx header 0x81, then idle 5000 clk -> no write, err_cnt+1. Next header 0x01 answers normally.
- Overrun: rx read 0x02, then rx read 0x03 during T_SEND -> only one response (regfile[2]); err_cnt+1.
- Reset mid-T_SEND: assert rst at bit 4 -> tx=1 at once, no further bits; after release, read of any address returns 0x00.

Source files
------------

// File: rtl/uart_reg_slave.sv
// Purpose: UART command slave that decodes read/write headers into a register file and answers reads with one tx frame.
// Latency: a write lands 1 clk after the data byte's stop-bit sample. A read response start bit begins RESP_DELAY+1 clks after the header stop sample.
// Backpressure: none on rx, because bytes are consumed as they arrive. A read that arrives while a response is pending is dropped and counted as overrun.
// Ports: clk, rst (async active-high), rx (serial in, idle high), tx (serial out, idle high),
//        wr_valid/wr_addr/wr_data (write strobe, addr/data held until the next write), err_cnt (error count).
// Optional: define UART_SLV_ERR_CNT_EN to get a saturating err_cnt. When it is undefined, err_cnt is tied to 0.
module uart_reg_slave #(
  parameter int CLK_PER_BIT    = 434,
  parameter int SAMPLE_POINT   = 216,
  parameter int CMD_ADDR_WIDTH = 7,
  parameter int CMD_DATA_WIDTH = 8,
  parameter int DATA_TIMEOUT   = 4340,
  parameter int RESP_DELAY     = 200
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic                      tx,
  output logic                      wr_valid,
  output logic [CMD_ADDR_WIDTH-1:0] wr_addr,
  output logic [CMD_DATA_WIDTH-1:0] wr_data,
  output logic [7:0]                err_cnt
);

  localparam int AW    = CMD_ADDR_WIDTH;
  localparam int DW    = CMD_DATA_WIDTH;
  localparam int DEPTH = 2 ** AW;
  localparam int CW    = $clog2(CLK_PER_BIT);
  localparam int TW    = $clog2(DATA_TIMEOUT + 1);
  localparam int LW    = $clog2(RESP_DELAY + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] SAMPLE_L  = CW'(SAMPLE_POINT);
  localparam logic [TW-1:0] TO_L      = TW'(DATA_TIMEOUT);
  localparam logic [LW-1:0] DLY_LAST  = LW'(RESP_DELAY - 1);
  localparam logic [3:0]    IDX_DLAST = 4'(DW);
  localparam logic [3:0]    IDX_PAR   = 4'(DW + 1);
  localparam logic [3:0]    IDX_STOP  = 4'(DW + 2);

  typedef enum logic       {R_HDR, R_DATA} p_state_t;
  typedef enum logic [1:0] {T_IDLE, T_DLY, T_SEND} t_state_t;

  // ---------------- rx front end + byte receiver ----------------
  logic [2:0]    rx_sh_q, rx_sh_d;
  logic          rx_prev_q, rx_prev_d;
  logic          rx_sync;
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [DW-1:0] sh_q, sh_d;
  logic          par_q, par_d;
  logic          start_edge, byte_done, byte_ok;

  assign rx_sync = rx_sh_q[2];

  always_comb begin
    rx_sh_d    = {rx_sh_q[1:0], rx};
    rx_prev_d  = rx_sync;
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    sh_d       = sh_q;
    par_d      = par_q;
    start_edge = 1'b0;
    byte_done  = 1'b0;
    byte_ok    = 1'b0;
    if (!busy_q) begin
      if (rx_prev_q && !rx_sync) begin
        start_edge = 1'b1;
        busy_d     = 1'b1;
        cnt_d      = '0;
        idx_d      = 4'd0;
        par_d      = 1'b0;
      end
    end else begin
      if (cnt_q == BIT_LAST) begin
        cnt_d = '0;
        idx_d = idx_q + 4'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      if (cnt_q == SAMPLE_L) begin
        if (idx_q == 4'd0) begin
          // If the start bit is high at mid-bit, it was a glitch. Drop it quietly.
          if (rx_sync) busy_d = 1'b0;
        end else if (idx_q <= IDX_DLAST) begin
          sh_d  = {rx_sync, sh_q[DW-1:1]};
          par_d = par_q ^ rx_sync;
        end else if (idx_q == IDX_PAR) begin
          par_d = par_q ^ rx_sync;
        end else begin
          // Stop-bit sample. Re-arm right away so the next start edge is caught.
          byte_done = 1'b1;
          byte_ok   = par_q & rx_sync;
          busy_d    = 1'b0;
        end
      end
    end
  end

  // ---------------- protocol FSM ----------------
  p_state_t          p_state_q, p_state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [TW-1:0]     to_cnt_q, to_cnt_d;
  logic              to_run_q, to_run_d;
  logic              wr_valid_q, wr_valid_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [DW-1:0]     wr_data_q, wr_data_d;
  logic              rd_req, rx_err;
  logic [AW-1:0]     rd_addr;
  logic [DW-1:0]     rf_q [DEPTH];
  logic [DW-1:0]     rf_d [DEPTH];

  always_comb begin
    p_state_d  = p_state_q;
    addr_d     = addr_q;
    to_cnt_d   = to_cnt_q;
    to_run_d   = to_run_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_req     = 1'b0;
    rd_addr    = sh_q[AW-1:0];
    rx_err     = 1'b0;
    if (to_run_q) to_cnt_d = to_cnt_q + 1'b1;
    // The data byte has started arriving, so the timeout no longer applies.
    if (start_edge) to_run_d = 1'b0;
    if (byte_done) begin
      if (!byte_ok) begin
        rx_err    = 1'b1;
        p_state_d = R_HDR;
        to_run_d  = 1'b0;
      end else if (p_state_q == R_HDR) begin
        if (sh_q[DW-1]) begin
          addr_d    = sh_q[AW-1:0];
          p_state_d = R_DATA;
          to_cnt_d  = '0;
          to_run_d  = 1'b1;
        end else begin
          rd_req = 1'b1;
        end
      end else begin
        wr_valid_d = 1'b1;
        wr_addr_d  = addr_q;
        wr_data_d  = sh_q;
        p_state_d  = R_HDR;
        to_run_d   = 1'b0;
      end
    end else if (p_state_q == R_DATA && to_run_q && !start_edge && to_cnt_q == TO_L) begin
      rx_err    = 1'b1;
      p_state_d = R_HDR;
      to_run_d  = 1'b0;
    end
  end

  always_comb begin
    rf_d = rf_q;
    if (wr_valid_d) rf_d[addr_q] = sh_q;
  end

  // ---------------- response FSM ----------------
  t_state_t      t_state_q, t_state_d;
  logic [LW-1:0] dly_q, dly_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [3:0]    tidx_q, tidx_d;
  logic [DW-1:0] tdata_q, tdata_d;
  logic          tx_q, tx_d;
  logic          overrun, err_ev;

  // Line level for frame bit idx: start, data LSB first, odd parity, stop.
  function automatic logic tx_bit(input logic [3:0] idx, input logic [DW-1:0] d);
    logic [DW-1:0] s;
    s = d >> (idx - 4'd1);
    if (idx == 4'd0)           return 1'b0;
    else if (idx <= IDX_DLAST) return s[0];
    else if (idx == IDX_PAR)   return ~^d;
    else                       return 1'b1;
  endfunction

  always_comb begin
    t_state_d = t_state_q;
    dly_d     = dly_q;
    tcnt_d    = tcnt_q;
    tidx_d    = tidx_q;
    tdata_d   = tdata_q;
    tx_d      = tx_q;
    overrun   = 1'b0;
    case (t_state_q)
      T_IDLE: begin
        if (rd_req) begin
          // Read from the next-state array so that a same-cycle write is visible.
          tdata_d   = rf_d[rd_addr];
          dly_d     = '0;
          t_state_d = T_DLY;
        end
      end
      T_DLY: begin
        if (dly_q == DLY_LAST) begin
          t_state_d = T_SEND;
          tcnt_d    = '0;
          tidx_d    = 4'd0;
          tx_d      = 1'b0;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      T_SEND: begin
        if (tcnt_q == BIT_LAST) begin
          tcnt_d = '0;
          if (tidx_q == IDX_STOP) begin
            t_state_d = T_IDLE;
            tx_d      = 1'b1;
          end else begin
            tidx_d = tidx_q + 4'd1;
            tx_d   = tx_bit(tidx_q + 4'd1, tdata_q);
          end
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: t_state_d = T_IDLE;
    endcase
    if (rd_req && t_state_q != T_IDLE) overrun = 1'b1;
  end

  assign err_ev = rx_err | overrun;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sh_q    <= 3'b111;
      rx_prev_q  <= 1'b1;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= 4'd0;
      sh_q       <= '0;
      par_q      <= 1'b0;
      p_state_q  <= R_HDR;
      addr_q     <= '0;
      to_cnt_q   <= '0;
      to_run_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      t_state_q  <= T_IDLE;
      dly_q      <= '0;
      tcnt_q     <= '0;
      tidx_q     <= 4'd0;
      tdata_q    <= '0;
      tx_q       <= 1'b1;
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
    end else begin
      rx_sh_q    <= rx_sh_d;
      rx_prev_q  <= rx_prev_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sh_q       <= sh_d;
      par_q      <= par_d;
      p_state_q  <= p_state_d;
      addr_q     <= addr_d;
      to_cnt_q   <= to_cnt_d;
      to_run_q   <= to_run_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      t_state_q  <= t_state_d;
      dly_q      <= dly_d;
      tcnt_q     <= tcnt_d;
      tidx_q     <= tidx_d;
      tdata_q    <= tdata_d;
      tx_q       <= tx_d;
      rf_q       <= rf_d;
    end
  end

`ifdef UART_SLV_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_ev && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= 8'd0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_err_ev;
  assign unused_err_ev = err_ev;
  assign err_cnt       = 8'd0;
`endif

  assign tx       = tx_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_uart_reg_slave.sv
// Bench for uart_reg_slave. It uses shortened bit timing, drives rx frames, and decodes tx frames in a line monitor.
// A table of single-transaction vectors is followed by hand-written timeout, overrun and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_uart_reg_slave;
  localparam int CPB    = 16;
  localparam int SP     = 8;
  localparam int DTO    = 160;
  localparam int RDLY   = 20;
  localparam int SETTLE = RDLY + 12 * CPB + 40;
`ifdef UART_SLV_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       tx;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] err_cnt;

  always #10 clk = ~clk;

  uart_reg_slave #(
    .CLK_PER_BIT(CPB), .SAMPLE_POINT(SP), .CMD_ADDR_WIDTH(7), .CMD_DATA_WIDTH(8),
    .DATA_TIMEOUT(DTO), .RESP_DELAY(RDLY)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .err_cnt(err_cnt)
  );

  int checks = 0;
  int errors = 0;
  int err_model = 0;
  int wr_cnt = 0;
  logic [9:0] mon_q[$];   // {stop, parity, data}

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_err();
    if (!ERR_EN) return 0;
    return (err_model > 255) ? 255 : err_model;
  endfunction

  // write strobe counter
  always @(negedge clk) if (!rst && wr_valid) wr_cnt++;

  // tx line decoder, which discards any frame that is cut by reset
  initial begin
    logic       tx_prev;
    logic [9:0] frm;
    bit         aborted;
    tx_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && tx_prev && !tx) begin
        aborted = 1'b0;
        frm     = '0;
        repeat (CPB / 2) begin @(negedge clk); if (rst) aborted = 1'b1; end
        for (int i = 0; i < 10; i++) begin
          repeat (CPB) begin @(negedge clk); if (rst) aborted = 1'b1; end
          frm[i] = tx;
        end
        if (!aborted) mon_q.push_back(frm);
      end
      tx_prev = tx;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit flip);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ flip, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx = f[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic chk_resp(input string name, input logic [7:0] exp_d);
    chk({name, ".rsp_cnt"}, mon_q.size(), 1);
    if (mon_q.size() > 0) begin
      chk({name, ".rsp_data"}, int'(mon_q[0][7:0]), int'(exp_d));
      chk({name, ".rsp_par"}, int'(mon_q[0][8]), int'(~^exp_d));
      chk({name, ".rsp_stop"}, int'(mon_q[0][9]), 1);
    end
  endtask

  typedef struct {
    string      name;
    logic [7:0] b0;
    bit         flip;
    bit         two;
    int         gap;
    logic [7:0] b1;
    bit         exp_wr;
    logic [6:0] wa;
    logic [7:0] wd;
    bit         exp_rsp;
    logic [7:0] rd;
    bit         err;
  } vec_t;

  localparam int NV = 11;
  vec_t vt [NV];

  initial begin : watchdog
    #(2_000_000);
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc0;
    int k;
    vt[0]  = '{"rd_rst",  8'h05, 1'b0, 1'b0,   0, 8'h00, 1'b0, 7'h00, 8'h00, 1'b1, 8'h00, 1'b0};
    vt[1]  = '{"wr_0a",   8'h8A, 1'b0, 1'b1, 100, 8'h3C, 1'b1, 7'h0A, 8'h3C, 1'b0, 8'h00, 1'b0};
    vt[2]  = '{"rd_0a",   8'h0A, 1'b0, 1'b0,   0, 8'h00, 1'b0, 7'h00, 8'h00, 1'b1, 8'h3C, 1'b0};
    vt[3]  = '{"par_err", 8'h85, 1'b1, 1'b0,   0, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0, 8'h00, 1'b1};
    vt[4]  = '{"rd_05",   8'h05, 1'b0, 1'b0,   0, 8'h00, 1'b0, 7'h00, 8'h00, 1'b1, 8'h00, 1'b0};
    vt[5]  = '{"wr_7f",   8'hFF, 1'b0, 1'b1,  40, 8'hA5, 1'b1, 7'h7F, 8'hA5, 1'b0, 8'h00, 1'b0};
    vt[6]  = '{"rd_7f",   8'h7F, 1'b0, 1'b0,   0, 8'h00, 1'b0, 7'h00, 8'h00, 1'b1, 8'hA5, 1'b0};
    vt[7]  = '{"wr_03",   8'h83, 1'b0, 1'b1,  10, 8'h07, 1'b1, 7'h03, 8'h07, 1'b0, 8'h00, 1'b0};
    vt[8]  = '{"rd_03",   8'h03, 1'b0, 1'b0,   0, 8'h00, 1'b0, 7'h00, 8'h00, 1'b1, 8'h07, 1'b0};
    vt[9]  = '{"wr_02",   8'h82, 1'b0, 1'b1,  60, 8'h5A, 1'b1, 7'h02, 8'h5A, 1'b0, 8'h00, 1'b0};
    vt[10] = '{"rd_00",   8'h00, 1'b0, 1'b0,   0, 8'h00, 1'b0, 7'h00, 8'h00, 1'b1, 8'h00, 1'b0};

    // reset state
    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst.tx", int'(tx), 1);
    chk("rst.wr_valid", int'(wr_valid), 0);
    chk("rst.wr_addr", int'(wr_addr), 0);
    chk("rst.wr_data", int'(wr_data), 0);
    chk("rst.err_cnt", int'(err_cnt), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // table of single transactions
    for (int i = 0; i < NV; i++) begin
      wc0 = wr_cnt;
      mon_q.delete();
      send_byte(vt[i].b0, vt[i].flip);
      if (vt[i].two) begin
        repeat (vt[i].gap) @(negedge clk);
        send_byte(vt[i].b1, 1'b0);
      end
      repeat (SETTLE) @(negedge clk);
      if (vt[i].err) err_model++;
      chk({vt[i].name, ".wr_cnt"}, wr_cnt - wc0, int'(vt[i].exp_wr));
      if (vt[i].exp_wr) begin
        chk({vt[i].name, ".wr_addr"}, int'(wr_addr), int'(vt[i].wa));
        chk({vt[i].name, ".wr_data"}, int'(wr_data), int'(vt[i].wd));
      end
      if (vt[i].exp_rsp) chk_resp(vt[i].name, vt[i].rd);
      else chk({vt[i].name, ".rsp_cnt"}, mon_q.size(), 0);
      chk({vt[i].name, ".err_cnt"}, int'(err_cnt), exp_err());
    end

    // data timeout: header only, then a long idle
    wc0 = wr_cnt;
    mon_q.delete();
    send_byte(8'h81, 1'b0);
    repeat (DTO + 150) @(negedge clk);
    err_model++;
    chk("timeout.wr_cnt", wr_cnt - wc0, 0);
    chk("timeout.err_cnt", int'(err_cnt), exp_err());
    send_byte(8'h01, 1'b0);
    repeat (SETTLE) @(negedge clk);
    chk("timeout.next_wr_cnt", wr_cnt - wc0, 0);
    chk_resp("timeout.next", 8'h00);

    // overrun: the second read lands while the first response is on the line
    mon_q.delete();
    send_byte(8'h02, 1'b0);
    repeat (2) @(negedge clk);
    send_byte(8'h03, 1'b0);
    repeat (SETTLE + 200) @(negedge clk);
    err_model++;
    chk_resp("overrun", 8'h5A);
    chk("overrun.err_cnt", int'(err_cnt), exp_err());

    // reset in the middle of a response (reg 3 = 0x07, so data bit 3 is low)
    mon_q.delete();
    send_byte(8'h03, 1'b0);
    k = 0;
    while (tx !== 1'b0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("rstmid.start_seen", int'(k < 500), 1);
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    chk("rstmid.tx_bit4", int'(tx), 0);
    rst = 1'b1;
    #1;
    chk("rstmid.tx_now", int'(tx), 1);
    err_model = 0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx == 1'b0) k++;
    end
    chk("rstmid.tx_low_cycles", k, 0);
    chk("rstmid.rsp_cnt", mon_q.size(), 0);
    chk("rstmid.wr_addr", int'(wr_addr), 0);
    chk("rstmid.err_cnt", int'(err_cnt), exp_err());
    send_byte(8'h0A, 1'b0);
    repeat (SETTLE) @(negedge clk);
    chk_resp("rstmid.rd_0a", 8'h00);
    mon_q.delete();
    send_byte(8'h03, 1'b0);
    repeat (SETTLE) @(negedge clk);
    chk_resp("rstmid.rd_03", 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
